// File: rtl/bool_check_pkg.sv
// -----------------------------------------------------------------------------
// bool_check_pkg
// Shared types and helpers for the boolean check sequencer.
//   - bool_check_state_t : FSM state type (also exported on the debug port)
//   - ST_*               : state encodings
//   - clog2_min1()       : ceil(log2(n)) clamped to at least 1 bit
// -----------------------------------------------------------------------------
package bool_check_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_CHECK  = ST_CHECK,
        S_REPORT = ST_REPORT,
        S_DONE   = ST_DONE
    } bool_check_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bool_check_settle_timer.sv
// -----------------------------------------------------------------------------
// bool_check_settle_timer
// Loadable down-counter used to hold the sequencer in SETTLE.
//   i_clk, i_rst    : clock, async active-high reset
//   i_load          : load i_load_val (has priority over i_dec)
//   i_load_val      : value loaded on i_load
//   i_dec           : decrement by one, stops at zero
//   o_expired       : count is zero
// -----------------------------------------------------------------------------
module bool_check_settle_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/bool_check_sequencer.sv
// -----------------------------------------------------------------------------
// bool_check_sequencer
// Snapshots expected values and an enable mask on start, waits a settle
// interval, then walks the observed booleans in index order, reporting each
// enabled check over a valid/ready channel and ending with a pass/fail summary.
//
// Ports:
//   i_clk, i_rst      : clock, async active-high reset
//   i_start           : begin a run (honoured only in IDLE)
//   i_obs             : live observed booleans
//   i_expected        : expected values, captured at start
//   i_mask            : 1 = check enabled, captured at start
//   o_busy            : from the cycle after start through the done cycle
//   o_done            : one-cycle pulse at run end
//   o_pass            : summary result, valid from done until next start
//   o_fail_count      : number of mismatching enabled checks (saturating)
//   o_fail_idx        : index of first mismatch, 0 if none
//   o_rpt_valid/ready : per-check report handshake
//   o_rpt_idx/o_rpt_ok: report payload
//   o_dbg_state       : current FSM state
//
// Report channel: a report transfers on a rising edge where o_rpt_valid and
// i_rpt_ready are both high; while o_rpt_valid is high and i_rpt_ready is low,
// o_rpt_idx and o_rpt_ok stay unchanged and o_rpt_valid stays high.
// -----------------------------------------------------------------------------
module bool_check_sequencer
    import bool_check_pkg::*;
#(
    parameter int NUM_CHECKS    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = clog2_min1(NUM_CHECKS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NUM_CHECKS-1:0] i_obs,
    input  logic [NUM_CHECKS-1:0] i_expected,
    input  logic [NUM_CHECKS-1:0] i_mask,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [IDX_W:0]        o_fail_count,
    output logic [IDX_W-1:0]      o_fail_idx,
    output logic                  o_rpt_valid,
    input  logic                  i_rpt_ready,
    output logic [IDX_W-1:0]      o_rpt_idx,
    output logic                  o_rpt_ok,
    output bool_check_state_t     o_dbg_state
);

    localparam int CNT_W         = clog2_min1(SETTLE_CYCLES + 1);
    // Counter is loaded with N-1 and SETTLE exits when it reads zero, so the
    // state is occupied for exactly SETTLE_CYCLES cycles.
    localparam int SETTLE_LOAD_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LOAD_I);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W:0]   FAIL_MAX    = (IDX_W + 1)'(NUM_CHECKS);

    bool_check_state_t     r_state;
    logic [NUM_CHECKS-1:0] r_exp;
    logic [NUM_CHECKS-1:0] r_mask;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [IDX_W:0]        r_fail_count;
    logic [IDX_W-1:0]      r_fail_idx;
    logic                  r_rpt_valid;
    logic [IDX_W-1:0]      r_rpt_idx;
    logic                  r_rpt_ok;

    logic                  w_load;
    logic                  w_expired;
    logic                  w_fail_inc;
    logic [IDX_W:0]        w_fail_count_nxt;

    assign w_load = (r_state == S_IDLE) && i_start;

    bool_check_settle_timer #(.W(CNT_W)) u_settle (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (r_state == S_SETTLE),
        .o_expired  (w_expired)
    );

    // Failure accounting happens on the report handshake, using the payload
    // that was frozen in CHECK.
    assign w_fail_inc       = (r_state == S_REPORT) && i_rpt_ready && !r_rpt_ok
                              && (r_fail_count != FAIL_MAX);
    assign w_fail_count_nxt = w_fail_inc ? r_fail_count + 1'b1 : r_fail_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_exp        <= '0;
            r_mask       <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_fail_idx   <= '0;
            r_rpt_valid  <= 1'b0;
            r_rpt_idx    <= '0;
            r_rpt_ok     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_exp        <= i_expected;
                        r_mask       <= i_mask;
                        r_pass       <= 1'b0;
                        r_fail_count <= '0;
                        r_fail_idx   <= '0;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
                    end
                end
                S_SETTLE: begin
                    if (w_expired) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_mask[r_idx]) begin
                        r_rpt_ok    <= (i_obs[r_idx] == r_exp[r_idx]);
                        r_rpt_idx   <= r_idx;
                        r_rpt_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end else if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_fail_count == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (i_rpt_ready) begin
                        r_rpt_valid  <= 1'b0;
                        r_fail_count <= w_fail_count_nxt;
                        if (w_fail_inc && (r_fail_count == '0)) begin
                            r_fail_idx <= r_idx;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_count_nxt == '0);
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_fail_count = r_fail_count;
    assign o_fail_idx   = r_fail_idx;
    assign o_rpt_valid  = r_rpt_valid;
    assign o_rpt_idx    = r_rpt_idx;
    assign o_rpt_ok     = r_rpt_ok;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bool_check_sequencer.sv
module tb_bool_check_sequencer;
  import bool_check_pkg::*;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              i_start;
  logic [N-1:0]      i_obs, i_expected, i_mask;
  logic              i_rpt_ready;
  logic              o_busy, o_done, o_pass, o_rpt_valid, o_rpt_ok;
  logic [IW:0]       o_fail_count;
  logic [IW-1:0]     o_fail_idx, o_rpt_idx;
  bool_check_state_t o_dbg_state;

  bool_check_sequencer #(.NUM_CHECKS(N), .SETTLE_CYCLES(S)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_obs        (i_obs),
    .i_expected   (i_expected),
    .i_mask       (i_mask),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_fail_count (o_fail_count),
    .o_fail_idx   (o_fail_idx),
    .o_rpt_valid  (o_rpt_valid),
    .i_rpt_ready  (i_rpt_ready),
    .o_rpt_idx    (o_rpt_idx),
    .o_rpt_ok     (o_rpt_ok),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [IW:0] exp_q[$];   // {idx, ok} of each report still owed
  int   m_fc, m_fidx;
  logic m_pass;
  int   exp_base, stall_cnt, done_cyc, done_cnt;
  bit   run_active = 0;
  bit   prev_stall = 0, prev_done = 0;
  logic [IW-1:0] prev_idx;
  logic prev_ok;
  logic [IW:0] e_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", o_rpt_valid, 1);
        chk("stall_idx_held", o_rpt_idx, prev_idx);
        chk("stall_ok_held", o_rpt_ok, prev_ok);
      end
      if (prev_done) begin
        chk("done_one_cycle", o_done, 0);
        chk("busy_drop_after_done", o_busy, 0);
      end
      if (o_rpt_valid && i_rpt_ready) begin
        chk("report_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_item = exp_q.pop_front();
          chk("report_idx", o_rpt_idx, e_item[IW:1]);
          chk("report_ok", o_rpt_ok, e_item[0]);
        end
      end
      prev_stall = o_rpt_valid && !i_rpt_ready;
      if (prev_stall) begin
        stall_cnt++;
        prev_idx = o_rpt_idx;
        prev_ok  = o_rpt_ok;
      end
      if (o_done) begin
        chk("done_in_run", run_active, 1);
        done_cnt++;
        done_cyc = cyc;
        chk("reports_left", exp_q.size(), 0);
        chk("pass", o_pass, m_pass);
        chk("fail_count", o_fail_count, m_fc);
        chk("fail_idx", o_fail_idx, m_fidx);
        chk("done_cycle", cyc, exp_base + stall_cnt);
        chk("busy_at_done", o_busy, 1);
      end
      prev_done = o_done;
    end
  end

  // ---------------- driver ----------------
  // stall_mode: 0 = always ready, 1 = random ready, 2 = 3 stall cycles on idx2
  task automatic run_case(input logic [N-1:0] e, input logic [N-1:0] m, input logic [N-1:0] o,
                          input int stall_mode, input bit extra_start, input bit rst_mid,
                          input int lit_cyc, input int lit_fc, input int lit_fidx, input int lit_pass);
    int cost, start_cyc, stall_left;
    bit aborted;
    @(posedge clk); #1;
    i_expected = e;
    i_mask = m;
    i_obs = o;
    exp_q.delete();
    m_fc = 0;
    m_fidx = 0;
    cost = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        cost += 2;
        exp_q.push_back({IW'(i), o[i] == e[i]});
        if (o[i] != e[i]) begin
          if (m_fc == 0) m_fidx = i;
          m_fc++;
        end
      end else begin
        cost += 1;
      end
    end
    if (m_fc > N) m_fc = N;
    m_pass = (m_fc == 0);
    stall_cnt = 0;
    done_cnt = 0;
    stall_left = 3;
    aborted = 0;
    start_cyc = cyc;
    exp_base = start_cyc + 1 + S + cost;
    run_active = 1;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    chk("busy_after_start", o_busy, 1);
    chk("pass_cleared_at_start", o_pass, 0);
    for (int k = 0; k < 600 && done_cnt == 0 && !aborted; k++) begin
      i_start = extra_start && (k % 4 == 1);
      case (stall_mode)
        1: i_rpt_ready = ($urandom_range(0, 3) != 0);
        2: begin
          i_rpt_ready = !(o_rpt_valid && o_rpt_idx == 2 && stall_left > 0);
          if (!i_rpt_ready) stall_left--;
        end
        default: i_rpt_ready = 1;
      endcase
      if (!i_rpt_ready && o_rpt_valid) i_obs[o_rpt_idx] = ~i_obs[o_rpt_idx];
      if (rst_mid && o_rpt_valid && o_rpt_idx == 4) begin
        rst = 1;
        #1;
        chk("rst_rpt_valid", o_rpt_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_done", o_done, 0);
        chk("rst_state", o_dbg_state, S_IDLE);
        aborted = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    i_start = 0;
    i_rpt_ready = 1;
    if (aborted) begin
      @(posedge clk); #1;
      rst = 0;
      exp_q.delete();
      run_active = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt, 0);
      return;
    end
    run_active = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("pass_held", o_pass, m_pass);
    chk("busy_idle", o_busy, 0);
    if (lit_cyc >= 0) chk("lit_done_cycle", done_cyc - start_cyc, lit_cyc);
    if (lit_fc >= 0) chk("lit_fail_count", o_fail_count, lit_fc);
    if (lit_fidx >= 0) chk("lit_fail_idx", o_fail_idx, lit_fidx);
    if (lit_pass >= 0) chk("lit_pass", o_pass, lit_pass);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] re, rm, ro;
    rst = 1;
    i_start = 0;
    i_obs = '0;
    i_expected = '0;
    i_mask = '0;
    i_rpt_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_pass", o_pass, 0);
    chk("reset_fail_count", o_fail_count, 0);
    chk("reset_fail_idx", o_fail_idx, 0);
    chk("reset_rpt_valid", o_rpt_valid, 0);
    chk("reset_rpt_idx", o_rpt_idx, 0);
    chk("reset_rpt_ok", o_rpt_ok, 0);
    chk("reset_state", o_dbg_state, S_IDLE);
    rst = 0;

    // all match
    run_case(8'hA5, 8'hFF, 8'hA5, 0, 0, 0, 19, 0, 0, 1);
    // mismatches at idx0 and idx6
    run_case(8'hE4, 8'hFF, 8'hA5, 0, 0, 0, 19, 2, 0, 0);
    // masked upper half
    run_case(8'hE4, 8'h0F, 8'hA5, 0, 0, 0, 15, 1, 0, 0);
    // three-cycle stall on idx2 with obs[2] toggling
    run_case(8'hA5, 8'hFF, 8'hA5, 2, 0, 0, 22, 0, 0, 1);
    // reset while idx4 is being reported, then a clean rerun
    run_case(8'hA5, 8'hFF, 8'hA5, 0, 0, 1, -1, -1, -1, -1);
    run_case(8'hA5, 8'hFF, 8'hA5, 0, 0, 0, 19, 0, 0, 1);
    // nothing enabled: every index costs one cycle
    run_case(8'hE4, 8'h00, 8'hA5, 0, 0, 0, 11, 0, 0, 1);
    // extra start pulses while busy are ignored
    run_case(8'hE4, 8'hFF, 8'hA5, 0, 1, 0, 19, 2, 0, 0);
    // every enabled check fails
    run_case(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 19, 8, 0, 0);

    for (int r = 0; r < 20; r++) begin
      re = N'($urandom_range(0, 255));
      rm = N'($urandom_range(0, 255));
      ro = N'($urandom_range(0, 255));
      run_case(re, rm, ro, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0, -1, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
